// File: rtl/regfile_multi.sv
// regfile_multi: parametrised register file with two datapath read ports,
// one datapath write port, a debug view/write port and a handshaked dump
// sequencer that streams every entry in index order.
module regfile_multi #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] r0addr,
   input  logic [ADDR_W-1:0] r1addr,
   output logic [DATA_W-1:0] r0data,
   output logic [DATA_W-1:0] r1data,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wena,
   input  logic [ADDR_W-1:0] swaddr,
   input  logic [DATA_W-1:0] swdata,
   input  logic              swena,
   output logic [DATA_W-1:0] dff,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic [DATA_W-1:0] ent [DEPTH];
   logic              w_ok;
   logic              sw_ok;

   state_t            state_reg;
   logic [ADDR_W-1:0] idx_reg;
   logic              valid_reg;
   logic              busy_reg;
   logic              done_reg;

   // An address is usable if it is implemented and is not the hardwired zero entry.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_A) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Stored value of an entry; unusable addresses read as zero.
   function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (a == ADDR_W'(i)) v = ent[i];
      end
      if (!addr_ok(a)) v = '0;
      return v;
   endfunction

   // Datapath read: forwards the value this cycle's write will store, debug write first.
   function automatic logic [DATA_W-1:0] rd_byp(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = rd(a);
      if (BYPASS != 0) begin
         if (sw_ok && (a == swaddr))     v = swdata;
         else if (w_ok && (a == waddr))  v = wdata;
      end
      return v;
   endfunction

   assign w_ok  = wena  && addr_ok(waddr);
   assign sw_ok = swena && addr_ok(swaddr);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
         logic [DATA_W-1:0] q_reg;
         // One entry: async clear, debug write has priority over the datapath write.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                         q_reg <= '0;
            else if (sw_ok && (swaddr == IDX))  q_reg <= swdata;
            else if (w_ok && (waddr == IDX))    q_reg <= wdata;
         end
         assign ent[gi] = q_reg;
      end
   endgenerate

   // Combinational read ports; view and dump ports never see in-flight writes.
   always_comb begin
      r0data    = rd_byp(r0addr);
      r1data    = rd_byp(r1addr);
      dff       = rd(swaddr);
      dump_data = rd(idx_reg);
   end

   // Dump sequencer: IDLE waits for start, RUN streams beats, DONE pulses once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (dump_start) begin
                  state_reg <= RUN;
                  idx_reg   <= '0;
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (dump_ready) begin
                  if (idx_reg == LAST_IDX) begin
                     state_reg <= DONE;
                     valid_reg <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     idx_reg <= idx_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               idx_reg   <= '0;
            end
            default: begin
               state_reg <= IDLE;
               idx_reg   <= '0;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign dump_valid = valid_reg;
   assign dump_addr  = idx_reg;
   assign dump_busy  = busy_reg;
   assign dump_done  = done_reg;

endmodule

// File: tb/tb_regfile_multi.sv
// tb_regfile_multi: directed bench over three configurations sharing one
// stimulus bus; expectations are queued by the stimulus and checked by a
// negedge monitor, dump beats are checked on every valid&ready handshake.
module tb_regfile_multi;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] r0addr, r1addr, waddr, swaddr;
   logic [DW-1:0] wdata, swdata;
   logic          wena, swena, dump_start, dump_ready;

   // u_byp: DEPTH 24, bypass on
   logic [DW-1:0] b_r0, b_r1, b_dff, b_dd;
   logic [AW-1:0] b_da;
   logic          b_dv, b_db, b_dn;
   // u_nob: DEPTH 32, zero register, bypass off
   logic [DW-1:0] n_r0, n_r1, n_dff, n_dd;
   logic [AW-1:0] n_da;
   logic          n_dv, n_db, n_dn;
   // u_dmp: DEPTH 4, used for dump sequencing
   logic [DW-1:0] d_r0, d_r1, d_dff, d_dd;
   logic [AW-1:0] d_da;
   logic          d_dv, d_db, d_dn;

   always #5 clk = ~clk;

   regfile_multi #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(24), .ZERO_REG(0), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .r0addr(r0addr), .r1addr(r1addr), .r0data(b_r0), .r1data(b_r1),
      .waddr(waddr), .wdata(wdata), .wena(wena), .swaddr(swaddr), .swdata(swdata), .swena(swena),
      .dff(b_dff), .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(b_dv),
      .dump_addr(b_da), .dump_data(b_dd), .dump_busy(b_db), .dump_done(b_dn));

   regfile_multi #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .r0addr(r0addr), .r1addr(r1addr), .r0data(n_r0), .r1data(n_r1),
      .waddr(waddr), .wdata(wdata), .wena(wena), .swaddr(swaddr), .swdata(swdata), .swena(swena),
      .dff(n_dff), .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(n_dv),
      .dump_addr(n_da), .dump_data(n_dd), .dump_busy(n_db), .dump_done(n_dn));

   regfile_multi #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) u_dmp (
      .clk(clk), .rst_n(rst_n), .r0addr(r0addr), .r1addr(r1addr), .r0data(d_r0), .r1data(d_r1),
      .waddr(waddr), .wdata(wdata), .wena(wena), .swaddr(swaddr), .swdata(swdata), .swena(swena),
      .dff(d_dff), .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(d_dv),
      .dump_addr(d_da), .dump_data(d_dd), .dump_busy(d_db), .dump_done(d_dn));

   localparam int S_BR0 = 0, S_BR1 = 1, S_BDFF = 2, S_NR0 = 3, S_NR1 = 4, S_NDFF = 5;
   localparam int S_DV = 6, S_DB = 7, S_DN = 8, S_DA = 9, S_DDFF = 10;

   int            checks = 0;
   int            errors = 0;
   int            sel_q[$];
   logic [DW-1:0] exp_q[$];
   string         name_q[$];
   logic [AW-1:0] ba_q[$];
   logic [DW-1:0] bd_q[$];

   function automatic logic [DW-1:0] pick(input int s);
      case (s)
         S_BR0:   return b_r0;
         S_BR1:   return b_r1;
         S_BDFF:  return b_dff;
         S_NR0:   return n_r0;
         S_NR1:   return n_r1;
         S_NDFF:  return n_dff;
         S_DV:    return {{(DW-1){1'b0}}, d_dv};
         S_DB:    return {{(DW-1){1'b0}}, d_db};
         S_DN:    return {{(DW-1){1'b0}}, d_dn};
         S_DA:    return {{(DW-AW){1'b0}}, d_da};
         S_DDFF:  return d_dff;
         default: return 'x;
      endcase
   endfunction

   task automatic expect_val(input int s, input logic [DW-1:0] v, input string n);
      sel_q.push_back(s);
      exp_q.push_back(v);
      name_q.push_back(n);
   endtask

   task automatic push_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ba_q.push_back(a);
      bd_q.push_back(d);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: drain queued expectations and check every dump handshake, away from posedge.
   always @(negedge clk) begin
      int            s;
      logic [DW-1:0] e, a;
      string         n;
      logic [AW-1:0] ea;
      while (sel_q.size() > 0) begin
         s = sel_q.pop_front();
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = pick(s);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
         end
      end
      if (d_dv && dump_ready) begin
         checks++;
         if (ba_q.size() == 0) begin
            errors++;
            $display("FAIL dump_beat: unexpected beat addr %0d data %h", d_da, d_dd);
         end else begin
            ea = ba_q.pop_front();
            e  = bd_q.pop_front();
            if (d_da !== ea || d_dd !== e) begin
               errors++;
               $display("FAIL dump_beat: got (%0d,%h) expected (%0d,%h)", d_da, d_dd, ea, e);
            end else begin
               $display("beat addr %0d data %h", d_da, d_dd);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [DW-1:0] model [24];
   int ready_pat [6] = '{1, 0, 1, 1, 0, 1};

   initial begin
      rst_n = 1'b0; r0addr = '0; r1addr = '0; waddr = '0; swaddr = '0;
      wdata = '0; swdata = '0; wena = 1'b0; swena = 1'b0;
      dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < 24; i++) model[i] = '0;

      // Reset state
      step();
      expect_val(S_BR0, 0, "reset_r0"); expect_val(S_BDFF, 0, "reset_dff");
      expect_val(S_DV, 0, "reset_valid"); expect_val(S_DB, 0, "reset_busy");
      expect_val(S_DN, 0, "reset_done"); expect_val(S_DA, 0, "reset_addr");
      step();
      rst_n = 1'b1;

      // Bypass vs no bypass
      step();
      wena = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; r0addr = 5'd3; r1addr = 5'd3;
      expect_val(S_BR0, 32'hDEADBEEF, "bypass_same_cycle");
      expect_val(S_NR0, 32'h0, "nobypass_same_cycle");
      step();
      wena = 1'b0;
      expect_val(S_NR0, 32'hDEADBEEF, "nobypass_next_cycle");
      expect_val(S_BR1, 32'hDEADBEEF, "bypass_r1_stored");
      model[3] = 32'hDEADBEEF;

      // Same-cycle conflict, debug write wins
      step();
      wena = 1'b1; swena = 1'b1; waddr = 5'd7; swaddr = 5'd7; wdata = 32'd1; swdata = 32'd2;
      r0addr = 5'd7;
      expect_val(S_BR0, 32'd2, "conflict_bypass");
      expect_val(S_NDFF, 32'd0, "conflict_dff_before");
      step();
      wena = 1'b0; swena = 1'b0;
      expect_val(S_BDFF, 32'd2, "conflict_dff_byp");
      expect_val(S_NDFF, 32'd2, "conflict_dff_nob");
      expect_val(S_NR0, 32'd2, "conflict_r0_nob");
      model[7] = 32'd2;

      // Hardwired zero register
      step();
      wena = 1'b1; waddr = 5'd0; wdata = 32'h55; r0addr = 5'd0; swaddr = 5'd0;
      expect_val(S_NR0, 32'h0, "zero_r0_same");
      expect_val(S_BR0, 32'h55, "nonzero_bypass_r0");
      step();
      wena = 1'b0;
      expect_val(S_NR0, 32'h0, "zero_r0_after");
      expect_val(S_NDFF, 32'h0, "zero_dff_after");
      expect_val(S_BDFF, 32'h55, "nonzero_dff_after");
      model[0] = 32'h55;

      // Out-of-range write on the DEPTH=24 file
      step();
      wena = 1'b1; waddr = 5'd30; wdata = 32'hAAAA; r1addr = 5'd30;
      expect_val(S_BR1, 32'h0, "oor_not_forwarded");
      expect_val(S_NR1, 32'h0, "depth32_nobypass_same");
      step();
      wena = 1'b0;
      expect_val(S_BR1, 32'h0, "oor_read_zero");
      expect_val(S_NR1, 32'hAAAA, "depth32_addr30");
      for (int i = 0; i < 24; i++) begin
         step();
         swaddr = AW'(i);
         expect_val(S_BDFF, model[i], $sformatf("entry_%0d_unchanged", i));
      end

      // Preload DEPTH=4 file and dump with toggling ready
      for (int i = 0; i < 4; i++) begin
         step();
         wena = 1'b1; waddr = AW'(i); wdata = 32'(10 + i);
      end
      for (int i = 0; i < 4; i++) push_beat(AW'(i), 32'(10 + i));
      step();
      wena = 1'b0; dump_start = 1'b1; dump_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         dump_start = 1'b0;
         dump_ready = ready_pat[k][0];
         expect_val(S_DV, 1, $sformatf("dump1_valid_k%0d", k));
         expect_val(S_DB, 1, $sformatf("dump1_busy_k%0d", k));
         if (k == 1) expect_val(S_DA, 1, "dump1_hold_addr1");
         if (k == 2) expect_val(S_DA, 1, "dump1_after_hold_addr1");
         if (k == 4) expect_val(S_DA, 3, "dump1_hold_addr3");
      end
      step();
      dump_ready = 1'b0;
      expect_val(S_DN, 1, "dump1_done_pulse");
      expect_val(S_DB, 1, "dump1_done_busy");
      expect_val(S_DV, 0, "dump1_done_novalid");
      step();
      expect_val(S_DN, 0, "dump1_done_once");
      expect_val(S_DB, 0, "dump1_idle_busy");

      // Dump with a write ahead of its beat and an ignored mid-dump start
      push_beat(0, 32'd10); push_beat(1, 32'd11); push_beat(2, 32'h99); push_beat(3, 32'd13);
      step();
      dump_start = 1'b1; dump_ready = 1'b1;
      step();
      dump_start = 1'b0;
      step();
      wena = 1'b1; waddr = 5'd2; wdata = 32'h99;
      step();
      wena = 1'b0; dump_start = 1'b1;
      step();
      dump_start = 1'b0;
      step();
      expect_val(S_DN, 1, "dump2_done_pulse");
      step();
      expect_val(S_DB, 0, "dump2_idle_busy");
      step();
      expect_val(S_DV, 0, "dump2_start_ignored");

      // Reset in the middle of a dump
      push_beat(0, 32'd10); push_beat(1, 32'd11);
      step();
      dump_start = 1'b1; dump_ready = 1'b1; swaddr = 5'd2;
      step();
      dump_start = 1'b0;
      step();
      step();
      dump_ready = 1'b0;
      expect_val(S_DA, 2, "midreset_at_index2");
      expect_val(S_DV, 1, "midreset_valid_before");
      step();
      rst_n = 1'b0;
      #1;
      expect_val(S_DV, 0, "midreset_valid");
      expect_val(S_DB, 0, "midreset_busy");
      expect_val(S_DN, 0, "midreset_no_done");
      expect_val(S_DA, 0, "midreset_addr");
      expect_val(S_DDFF, 0, "midreset_entry2");
      expect_val(S_BR0, 0, "midreset_byp_entry");
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(AW'(i), 32'h0);
      step();
      dump_start = 1'b1; dump_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         dump_start = 1'b0;
      end
      step();
      step();

      checks++;
      if (ba_q.size() != 0) begin
         errors++;
         $display("FAIL beats_outstanding: got %0d left expected 0", ba_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_multi.md
# regfile_multi

Parametrised register file: the successor to the fixed 32x64 dual-read file, with configurable width and depth, optional hardwired-zero register, optional write-to-read bypass, asynchronous clear, and a handshaked dump sequencer. It sits between the datapath, which uses two read ports and one write port, and the board switch/display debug logic, which uses a view port, a write port and a dump stream.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width
- DEPTH, 32, number of implemented entries; must satisfy DEPTH <= 2**ADDR_W and DEPTH >= 2
- ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- r0addr, r1addr  in  ADDR_W  datapath read addresses
- r0data, r1data  out  DATA_W  combinational read data
- waddr  in  ADDR_W  datapath write address
- wdata  in  DATA_W  datapath write data
- wena  in  1  datapath write enable
- swaddr  in  ADDR_W  debug address, shared by the view port and the debug write port
- swdata  in  DATA_W  debug write data
- swena  in  1  debug write enable
- dff  out  DATA_W  combinational view of entry swaddr; never bypassed
- dump_start  in  1  one-cycle request to stream all entries
- dump_ready  in  1  consumer ready
- dump_valid  out  1  dump beat valid
- dump_addr  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  contents of entry dump_addr
- dump_busy  out  1  sequencer not idle
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Storage: DEPTH x DATA_W flops. While rst_n = 0, every entry is asynchronously cleared to 0.
- Writes on posedge clk:
  - If wena, entry waddr is written with wdata.
  - If swena, entry swaddr is written with swdata.
  - If both are enabled and waddr == swaddr, swdata wins.
  - Writes to addresses >= DEPTH are discarded.
  - When ZERO_REG = 1, writes to address 0 are discarded.
- Reads are combinational:
  - Addresses >= DEPTH return 0.
  - When ZERO_REG = 1, address 0 returns 0.
- Bypass (BYPASS = 1): r0data and r1data return the value that the same cycle's write will store, using the priority above, when the read address matches a valid enabled write. Discarded writes are not forwarded.
- When BYPASS = 0, reads return the stored value only.
- dff and dump_data are never bypassed.
- Dump sequencer states: IDLE, RUN, DONE.
  - IDLE: dump_valid = 0 and dump_busy = 0. If dump_start = 1, go to RUN with index = 0.
  - RUN: dump_valid = 1, dump_busy = 1, dump_addr = index, dump_data = stored entry at index.
    - A beat transfers when dump_valid and dump_ready are both 1.
    - On a transfer with index == DEPTH-1, go to DONE.
    - On any other transfer, increment index.
    - Without a transfer, dump_addr and dump_data hold, except that dump_data tracks writes to the held entry.
  - DONE: dump_done = 1 and dump_busy = 1 for exactly one cycle, then go to IDLE.
  - dump_start is ignored in RUN and DONE.
- Writes remain fully functional during a dump. An entry written before its beat is streamed with its new value.

## Timing
- Reset values: dump_valid = 0, dump_busy = 0, dump_done = 0, dump_addr = 0, state = IDLE. r0data, r1data, dff and dump_data all read 0.
- Write latency: the stored value is visible on all read ports in the cycle after the posedge.
- With BYPASS = 1, r0data and r1data show the new value in the same cycle the write is presented.
- Dump timing:
  - The first beat is valid in the cycle after dump_start is sampled.
  - With dump_ready held at 1, a dump takes DEPTH beat cycles plus 1 DONE cycle.
  - The next dump_start is accepted in the cycle after DONE.
- Deasserting rst_n mid-dump immediately forces IDLE and clears all outputs and entries. No dump_done pulse is produced.
- dump_ready may be driven at any time. Its value outside RUN has no effect.

## Test plan
- Reset, then wena=1, waddr=3, wdata=0xDEAD_BEEF with r0addr=3 and BYPASS=1 → r0data=0xDEADBEEF in the same cycle. With BYPASS=0 → r0data=0 in that cycle and 0xDEADBEEF in the next.
- Same-cycle conflict: wena and swena both set, waddr=swaddr=7, wdata=1, swdata=2 → entry 7 = 2, and dff=2 in the next cycle.
- ZERO_REG=1: write 0x55 to address 0 → r0data=0 and dff=0. DEPTH=24, ADDR_W=5: write to address 30 → r1addr=30 reads 0, and entries 0-23 are unchanged.
- Dump of DEPTH=4 with entries {10,11,12,13} and dump_ready toggling 1,0,1,1,0,1 → beats (0,10),(1,11),(2,12),(3,13) in order. dump_addr holds while ready=0. dump_done pulses once, then dump_busy falls.
- During a dump of DEPTH=4, write 0x99 to entry 2 before its beat → beat 2 carries 0x99. A dump_start pulse mid-dump is ignored.
- Assert rst_n=0 while the dump is at index 2 → immediately dump_valid=0, dump_busy=0 and all entries read 0. A new dump_start after release streams all zeros from index 0.
